axi_pwm_core: RTL and testbench
===============================

Name: axi_pwm_core

Overview:
PWM generation core directly downstream of the AXI4-Lite register slave in the AXI_PWM IP. The slave's register outputs (control, period, duty, prescale, dead-time) arrive on cfg_* ports. The core keeps them in shadow registers and updates only on period boundaries, so the output never glitches. It drives a PWM pin, a complementary pin, and a one-cycle period-done pulse.

Parameters:
CNT_WIDTH, 16, width of period/duty counter
PRESCALE_WIDTH, 8, width of clock prescaler
DEADTIME_WIDTH, 8, width of dead-time count (used only with PWM_DEADTIME_EN)

Ports:
s00_axi_aclk  in  1  clock; all logic on rising edge
s00_axi_aresetn  in  1  reset; synchronous, active-low
cfg_enable  in  1  run request (level)
cfg_polarity  in  1  0: active-high output; 1: active-low
cfg_period  in  CNT_WIDTH  period minus 1, in ticks
cfg_duty  in  CNT_WIDTH  active ticks per period
cfg_prescale  in  PRESCALE_WIDTH  tick every prescale+1 clocks
cfg_deadtime  in  DEADTIME_WIDTH  dead-time clocks
cfg_update  in  1  one-cycle strobe: cfg_period/duty/prescale/polarity/deadtime are valid, commit them
pwm_out  out  1  PWM output, registered
pwm_out_n  out  1  complementary output, registered
period_done  out  1  one-cycle pulse per completed period
update_pending  out  1  committed config waiting for period boundary

Behaviour:
- Reset (s00_axi_aresetn=0 at clock edge):
  - State goes to IDLE.
  - Shadows, counters and pending are cleared.
  - pwm_out=0, pwm_out_n=0, period_done=0, update_pending=0.
- Shadows: per_sh, duty_sh, psc_sh, pol_sh, dt_sh.
- States: IDLE, RUN, STOP_PEND.
- IDLE:
  - Counters are held at 0.
  - pwm_out=pwm_out_n=pol_sh, which is the inactive level.
  - cfg_update loads the shadows at the next edge; update_pending stays 0.
  - cfg_enable=1 goes to RUN with cnt=0 and pre_cnt=0; first active output appears 1 cycle later.
- Prescaler:
  - pre_cnt counts 0..psc_sh.
  - tick=1 when pre_cnt==psc_sh, then pre_cnt wraps to 0.
  - psc_sh=0 gives a tick every clock.
- Main counter:
  - On tick, cnt increments.
  - At a tick with cnt==per_sh (the boundary), cnt goes to 0 and period_done pulses 1 on the following cycle.
  - per_sh=0 makes every tick a boundary.
- Raw output: raw = (cnt < duty_sh), compared unsigned.
  - duty_sh=0 gives 0%.
  - duty_sh > per_sh gives 100% with no toggle.
- Output timing: pwm_out = raw XOR pol_sh, and pwm_out_n = ~raw XOR pol_sh. Both are registered: 1 clock latency from cnt.
- cfg_update in RUN or STOP_PEND:
  - Sets update_pending.
  - At the next boundary, shadows load from the current cfg_* inputs and pending clears.
  - cfg_update on the same cycle as a boundary loads immediately and pending is never seen set.
  - Repeated updates before the boundary: the last one wins.
- RUN with cfg_enable=0 goes to STOP_PEND.
- STOP_PEND:
  - Continues the current period.
  - At the boundary, goes to IDLE and outputs go inactive the next cycle.
  - cfg_enable=1 before the boundary returns to RUN with no disturbance.
- period_done pulses on every boundary in RUN and STOP_PEND, including the final one.
- Reset asserted mid-period: outputs go inactive on the same edge and the pending update is discarded.
- Widths:
  - Counters do not overflow: per_sh ≤ 2^CNT_WIDTH-1, and cnt wraps only through the boundary rule.
  - cfg_* values are not range-checked.

Optional Feature:
PWM_DEADTIME_EN
- Defined:
  - A rising edge of raw asserts pwm_out only after dt_sh clocks with raw still 1.
  - A falling edge of raw asserts pwm_out_n only after dt_sh clocks with raw still 0.
  - During a dead interval both outputs are inactive.
  - A pulse shorter than or equal to dt_sh clocks is suppressed.
  - dt_sh=0 behaves as the macro undefined.
  - Adds one DEADTIME_WIDTH counter.
- Undefined: cfg_deadtime is ignored and no dead-time logic is built.

Test Plan:
- Basic run: reset, then cfg_update with period=9, duty=3, prescale=0, pol=0, then enable. Required: pwm_out is 3 clocks high / 7 low, period_done every 10 clocks, pwm_out_n is exactly the inverse.
- Boundary duties: duty=0 gives pwm_out constantly 0. duty=10 with period=9 gives pwm_out constantly 1. period_done still every 10 clocks in both.
- Prescale and polarity: prescale=3, period=4, duty=2, pol=1. Required: pwm_out low 8 clocks / high 12, period 20 clocks; IDLE level is 1.
- Shadow update: mid-period cfg_update duty=7. Required: update_pending=1 until the boundary, the old duty holds for the rest of the period, the new duty applies from the next period. An update coincident with a boundary applies immediately.
- Stop and restart: deassert enable at cnt=4. Required: the period completes, period_done pulses, outputs go inactive. Re-enable at cnt=6 of another period: no gap and no extra period_done. Reset mid-period: outputs 0 on the same edge.
- PWM_DEADTIME_EN, deadtime=2, period=9, duty=5: pwm_out high 3 clocks, pwm_out_n high 3 clocks, two 2-clock gaps with both low. duty=2: pwm_out never asserts.

Source files
------------

// File: rtl/axi_pwm_core.sv
// rtl/axi_pwm_core.sv - PWM core with shadow config committed on period boundaries.
// Optional dead-time insertion between pwm_out and pwm_out_n is built when PWM_DEADTIME_EN is defined.
module axi_pwm_core #(
  parameter int CNT_WIDTH      = 16,
  parameter int PRESCALE_WIDTH = 8,
  parameter int DEADTIME_WIDTH = 8
) (
  input  logic                      s00_axi_aclk,
  input  logic                      s00_axi_aresetn,
  input  logic                      cfg_enable,
  input  logic                      cfg_polarity,
  input  logic [CNT_WIDTH-1:0]      cfg_period,
  input  logic [CNT_WIDTH-1:0]      cfg_duty,
  input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
  input  logic [DEADTIME_WIDTH-1:0] cfg_deadtime,
  input  logic                      cfg_update,
  output logic                      pwm_out,
  output logic                      pwm_out_n,
  output logic                      period_done,
  output logic                      update_pending
);

  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;

  state_t                    state;
  logic [CNT_WIDTH-1:0]      cnt;
  logic [CNT_WIDTH-1:0]      per_sh;
  logic [CNT_WIDTH-1:0]      duty_sh;
  logic [PRESCALE_WIDTH-1:0] pre_cnt;
  logic [PRESCALE_WIDTH-1:0] psc_sh;
  logic                      pol_sh;
  logic                      pending;

  logic running;
  logic tick;
  logic boundary;
  logic raw;
  logic load_now;
  logic dt_ok;

  assign running  = (state != IDLE);
  assign tick     = running && (pre_cnt == psc_sh);
  assign boundary = tick && (cnt == per_sh);
  assign raw      = (cnt < duty_sh);
  // In IDLE a commit is immediate; while running it waits for the boundary.
  assign load_now = (state == IDLE) ? cfg_update : (boundary && (pending || cfg_update));

  assign update_pending = pending;

`ifdef PWM_DEADTIME_EN
  logic [DEADTIME_WIDTH-1:0] dt_sh;
  logic [DEADTIME_WIDTH-1:0] dt_cnt;
  logic [DEADTIME_WIDTH-1:0] dt_stable;
  logic                      raw_q;

  // dt_stable: clocks raw has held its current value before this one.
  always_comb begin
    dt_stable = (raw != raw_q) ? '0 : dt_cnt;
    dt_ok     = (dt_stable >= dt_sh);
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      dt_sh  <= '0;
      dt_cnt <= '0;
      raw_q  <= 1'b0;
    end else begin
      if (load_now) begin
        dt_sh <= cfg_deadtime;
      end
      if (state == IDLE) begin
        raw_q  <= 1'b0;
        dt_cnt <= '0;
      end else begin
        raw_q  <= raw;
        dt_cnt <= dt_ok ? dt_stable : dt_stable + 1'b1;
      end
    end
  end
`else
  logic unused_deadtime;
  assign unused_deadtime = ^cfg_deadtime;
  assign dt_ok           = 1'b1;
`endif

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      state       <= IDLE;
      cnt         <= '0;
      pre_cnt     <= '0;
      per_sh      <= '0;
      duty_sh     <= '0;
      psc_sh      <= '0;
      pol_sh      <= 1'b0;
      pending     <= 1'b0;
      pwm_out     <= 1'b0;
      pwm_out_n   <= 1'b0;
      period_done <= 1'b0;
    end else begin
      period_done <= boundary;

      if (load_now) begin
        per_sh  <= cfg_period;
        duty_sh <= cfg_duty;
        psc_sh  <= cfg_prescale;
        pol_sh  <= cfg_polarity;
        pending <= 1'b0;
      end else if (running && cfg_update) begin
        pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          cnt       <= '0;
          pre_cnt   <= '0;
          pwm_out   <= pol_sh;
          pwm_out_n <= pol_sh;
          if (cfg_enable) begin
            state <= RUN;
          end
        end
        default: begin
          pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
          if (boundary) begin
            cnt <= '0;
          end else if (tick) begin
            cnt <= cnt + 1'b1;
          end
          pwm_out   <= (raw & dt_ok) ^ pol_sh;
          pwm_out_n <= (~raw & dt_ok) ^ pol_sh;
          if (state == RUN) begin
            if (!cfg_enable) begin
              state <= STOP_PEND;
            end
          end else if (cfg_enable) begin
            state <= RUN;
          end else if (boundary) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_pwm_core.sv
// tb/tb_axi_pwm_core.sv - directed self-checking bench for axi_pwm_core.
module tb_axi_pwm_core;

  logic        tb_ACLK = 1'b0;
  logic        s00_axi_aresetn;
  logic        cfg_enable;
  logic        cfg_polarity;
  logic [15:0] cfg_period;
  logic [15:0] cfg_duty;
  logic [7:0]  cfg_prescale;
  logic [7:0]  cfg_deadtime;
  logic        cfg_update;
  logic        pwm_out;
  logic        pwm_out_n;
  logic        period_done;
  logic        update_pending;

  int n_checks = 0;
  int n_errors = 0;

  always #5 tb_ACLK = ~tb_ACLK;

  axi_pwm_core #(
    .CNT_WIDTH(16),
    .PRESCALE_WIDTH(8),
    .DEADTIME_WIDTH(8)
  ) dut (
    .s00_axi_aclk   (tb_ACLK),
    .s00_axi_aresetn(s00_axi_aresetn),
    .cfg_enable     (cfg_enable),
    .cfg_polarity   (cfg_polarity),
    .cfg_period     (cfg_period),
    .cfg_duty       (cfg_duty),
    .cfg_prescale   (cfg_prescale),
    .cfg_deadtime   (cfg_deadtime),
    .cfg_update     (cfg_update),
    .pwm_out        (pwm_out),
    .pwm_out_n      (pwm_out_n),
    .period_done    (period_done),
    .update_pending (update_pending)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_ACLK);
    #1;
  endtask

  // Reset, commit a config in IDLE, enable; the next step shows cnt=0.
  task automatic start_cfg(input int per, input int duty, input int psc, input bit pol, input int dt);
    cfg_enable      = 1'b0;
    cfg_update      = 1'b0;
    s00_axi_aresetn = 1'b0;
    step();
    step();
    s00_axi_aresetn = 1'b1;
    cfg_period      = 16'(per);
    cfg_duty        = 16'(duty);
    cfg_prescale    = 8'(psc);
    cfg_polarity    = pol;
    cfg_deadtime    = 8'(dt);
    cfg_update      = 1'b1;
    step();
    cfg_update      = 1'b0;
    cfg_enable      = 1'b1;
    step();
  endtask

  // Sample index i: pwm_out expected ((i % per_len) < hi_len) ^ pol, period_done at the last index.
  task automatic sample_run(input string tag, input int n, input int hi_len, input int per_len, input bit pol);
    int   lvl_err;
    int   pd_err;
    int   inv_err;
    int   pend_cnt;
    logic exp_lvl;
    logic exp_pd;
    lvl_err  = 0;
    pd_err   = 0;
    inv_err  = 0;
    pend_cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      exp_lvl = ((i % per_len) < hi_len) ^ pol;
      exp_pd  = ((i % per_len) == per_len - 1);
      if (pwm_out !== exp_lvl) lvl_err++;
      if (period_done !== exp_pd) pd_err++;
      if (pwm_out_n !== ~pwm_out) inv_err++;
      if (update_pending !== 1'b0) pend_cnt++;
    end
    check_val({tag, "_lvl_err"}, lvl_err, 0);
    check_val({tag, "_pd_err"}, pd_err, 0);
    check_val({tag, "_inv_err"}, inv_err, 0);
    check_val({tag, "_pend"}, pend_cnt, 0);
  endtask

  initial begin
    int   hi;
    int   pd;
    int   err;
    int   quiet;
    logic exp_lvl;
    logic exp_pd;

    s00_axi_aresetn = 1'b0;
    cfg_enable      = 1'b0;
    cfg_polarity    = 1'b0;
    cfg_period      = '0;
    cfg_duty        = '0;
    cfg_prescale    = '0;
    cfg_deadtime    = '0;
    cfg_update      = 1'b0;
    step();
    step();
    check_val("rst_pwm_out", int'(pwm_out), 0);
    check_val("rst_pwm_out_n", int'(pwm_out_n), 0);
    check_val("rst_period_done", int'(period_done), 0);
    check_val("rst_pending", int'(update_pending), 0);

    // Basic 3/10 waveform.
    start_cfg(9, 3, 0, 1'b0, 0);
    check_val("basic_idle_lvl", int'(pwm_out), 0);
    check_val("basic_idle_pend", int'(update_pending), 0);
    sample_run("basic", 20, 3, 10, 1'b0);

    start_cfg(9, 0, 0, 1'b0, 0);
    sample_run("duty0", 20, 0, 10, 1'b0);
    start_cfg(9, 10, 0, 1'b0, 0);
    sample_run("duty100", 20, 10, 10, 1'b0);

    // Prescale 3, period 5 ticks: 8 clocks low, 12 high with pol=1.
    start_cfg(4, 2, 3, 1'b1, 0);
    check_val("pol_idle_out", int'(pwm_out), 1);
    check_val("pol_idle_out_n", int'(pwm_out_n), 1);
    sample_run("psc_pol", 40, 8, 20, 1'b1);

    // Mid-period update of duty to 7, issued while cnt=2.
    start_cfg(9, 3, 0, 1'b0, 0);
    sample_run("upd_pre", 12, 3, 10, 1'b0);
    cfg_duty   = 16'd7;
    cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    check_val("upd_pend_set", int'(update_pending), 1);
    hi = int'(pwm_out);
    for (int k = 13; k <= 19; k++) begin
      step();
      if (k == 18) check_val("upd_pend_hold", int'(update_pending), 1);
      hi += int'(pwm_out);
    end
    check_val("upd_old_duty_hi", hi, 1);
    check_val("upd_pend_clear", int'(update_pending), 0);
    check_val("upd_boundary_pd", int'(period_done), 1);
    sample_run("upd_new", 10, 7, 10, 1'b0);

    // Update coincident with the boundary applies at once.
    sample_run("coinc_pre", 9, 7, 10, 1'b0);
    cfg_duty   = 16'd2;
    cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    check_val("coinc_pend", int'(update_pending), 0);
    check_val("coinc_pd", int'(period_done), 1);
    sample_run("coinc_new", 10, 2, 10, 1'b0);

    // Stop request at cnt=4: period completes, then outputs go inactive.
    start_cfg(9, 3, 0, 1'b0, 0);
    sample_run("stop_pre", 4, 3, 10, 1'b0);
    cfg_enable = 1'b0;
    pd  = 0;
    err = 0;
    for (int i = 4; i <= 9; i++) begin
      step();
      pd += int'(period_done);
      if (pwm_out !== 1'b0 || pwm_out_n !== 1'b1) err++;
    end
    check_val("stop_lvl_err", err, 0);
    check_val("stop_pd_cnt", pd, 1);
    check_val("stop_last_pd", int'(period_done), 1);
    step();
    check_val("stop_idle_out", int'(pwm_out), 0);
    check_val("stop_idle_out_n", int'(pwm_out_n), 0);
    check_val("stop_idle_pd", int'(period_done), 0);
    quiet = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      quiet += int'(pwm_out) + int'(pwm_out_n) + int'(period_done);
    end
    check_val("stop_idle_quiet", quiet, 0);

    // Restart, then a brief stop request at cnt=6 withdrawn the next cycle.
    cfg_enable = 1'b1;
    step();
    pd  = 0;
    err = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 6) cfg_enable = 1'b0;
      if (i == 7) cfg_enable = 1'b1;
      step();
      exp_lvl = ((i % 10) < 3);
      exp_pd  = ((i % 10) == 9);
      if (pwm_out !== exp_lvl || pwm_out_n !== ~exp_lvl || period_done !== exp_pd) err++;
      pd += int'(period_done);
    end
    check_val("reen_wave_err", err, 0);
    check_val("reen_pd_cnt", pd, 3);

    // Reset mid-period with an update pending.
    cfg_duty   = 16'd5;
    cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    check_val("mrst_pend_before", int'(update_pending), 1);
    check_val("mrst_out_before", int'(pwm_out), 1);
    cfg_enable      = 1'b0;
    s00_axi_aresetn = 1'b0;
    step();
    check_val("mrst_out", int'(pwm_out), 0);
    check_val("mrst_out_n", int'(pwm_out_n), 0);
    check_val("mrst_pend", int'(update_pending), 0);
    s00_axi_aresetn = 1'b1;

`ifdef PWM_DEADTIME_EN
    // dt=2, duty 5/10: pwm_out at cnt 2..4, pwm_out_n at cnt 7..9.
    start_cfg(9, 5, 0, 1'b0, 2);
    err = 0;
    hi  = 0;
    pd  = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      exp_lvl = ((i % 10) >= 2) && ((i % 10) <= 4);
      exp_pd  = ((i % 10) >= 7);
      if (pwm_out !== exp_lvl || pwm_out_n !== exp_pd) err++;
      if (pwm_out === 1'b0 && pwm_out_n === 1'b0) hi++;
    end
    check_val("dt_wave_err", err, 0);
    check_val("dt_both_low", hi, 8);
    start_cfg(9, 2, 0, 1'b0, 2);
    hi = 0;
    pd = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      hi += int'(pwm_out);
      pd += int'(pwm_out_n);
    end
    check_val("dt_short_hi", hi, 0);
    check_val("dt_short_n_hi", pd, 12);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
